if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the ARM pipeline.
- Owns the PC and runs a single-outstanding request/acknowledge handshake to instruction memory.
- Consumes Freeze (the Hazard output of the hazard unit) to hold the IF/ID register, and Branch_Taken/Branch_Addr from EXE to redirect and flush.
- Feeds PC_out/Instruction/IF_Valid to the ID stage, whose Src1/Src2 go back to the hazard unit.

Parameters:
ADDR_W, 32, PC and memory address width
INSTR_W, 32, instruction width
PC_STEP, 4, PC increment per fetched instruction

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-low
Freeze  input  1  hazard stall from hazard unit; 1 = ID cannot accept, hold IF/ID
Branch_Taken  input  1  redirect request from EXE
Branch_Addr  input  ADDR_W  redirect target
imem_req  output  1  fetch request valid
imem_addr  output  ADDR_W  fetch address, stable while imem_req=1
imem_ack  input  1  response valid; only meaningful while imem_req=1
imem_rdata  input  INSTR_W  instruction, valid with imem_ack
PC_out  output  ADDR_W  IF/ID: fetch address + PC_STEP of held instruction
Instruction  output  INSTR_W  IF/ID: held instruction (0 = bubble)
IF_Valid  output  1  IF/ID: 1 = Instruction is real

Behaviour:
- Interface fixed: one clock `clk`; reset `rst` synchronous, active-low.
- Reset (rst=0 at edge):
  - PC=0, state=IDLE.
  - PC_out=0, Instruction=0, IF_Valid=0, imem_req=0, holding buffer invalid.
  - Reset mid-transaction abandons the outstanding request; the memory model must tolerate this.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: one cycle after reset release; imem_req=0; next FETCH.
- FETCH: imem_req=1, imem_addr=PC. imem_ack may arrive in the first FETCH cycle (zero wait states) or later; req and addr stay stable until ack.
  - ack, Freeze=0: IF/ID <= {PC+PC_STEP, imem_rdata, 1}; PC <= PC+PC_STEP; stay FETCH, issuing the next address next cycle. Sustains 1 instruction/cycle with a zero-wait memory.
  - ack, Freeze=1: buffer <= {PC+PC_STEP, imem_rdata}; PC <= PC+PC_STEP; IF/ID unchanged; go HOLD.
  - no ack, Freeze=0: IF/ID <= bubble {0,0,0}.
  - no ack, Freeze=1: IF/ID unchanged.
- HOLD: imem_req=0; IF/ID unchanged while Freeze=1. When Freeze=0: IF/ID <= {buffer,1}; go FETCH.
- DRAIN: imem_req=1 with the old address held until ack. The response is discarded and the IF/ID register is written with a bubble every cycle. On ack go FETCH at the current PC.
- Branch_Taken=1: highest priority, overrides Freeze in every state. PC <= Branch_Addr; IF/ID <= bubble; buffer invalidated. Next state:
  - FETCH with ack same cycle: FETCH; the response is dropped.
  - FETCH without ack: DRAIN.
  - DRAIN: stays DRAIN; PC updated again and the last target wins.
  - HOLD: FETCH.
  - IDLE: FETCH.
- PC arithmetic: modulo 2^ADDR_W; 0xFFFFFFFC + 4 wraps to 0 with no flag.
- No more than one request outstanding at any time.
- imem_req never drops before ack, except on reset.

Test Plan:
- Reset then zero-wait memory returning 0xE0000000+addr: imem_req rises 1 cycle after release; IF/ID shows PC_out=4,8,12 with Instruction=0xE0000000,0xE0000004,0xE0000008 on consecutive cycles, IF_Valid=1.
- Memory with 2 wait states: each instruction preceded by 2 bubble cycles (IF_Valid=0, Instruction=0); imem_addr stable during the wait.
- Freeze=1 for 3 cycles coinciding with ack of addr 8: IF/ID holds the addr-4 instruction for 3 cycles. Next cycle after Freeze falls, IF/ID shows PC_out=12 with the addr-8 instruction; no request is issued while in HOLD.
- Branch_Taken=1, Branch_Addr=0x100, issued while the addr-0x20 request is waiting: DRAIN until ack, addr-0x20 data never reaches IF/ID. The next request has imem_addr=0x100 and the first valid instruction has PC_out=0x104.
- Branch_Taken and Freeze both 1 in HOLD: buffer discarded, IF/ID bubble, next request addr=Branch_Addr.
- PC=0xFFFFFFFC fetched with ack: PC_out=0x00000000, next imem_addr=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC and keeps one request outstanding to instruction memory.
module if_fetch_stage #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int PC_STEP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Freeze,
  input  logic               Branch_Taken,
  input  logic [ADDR_W-1:0]  Branch_Addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  PC_out,
  output logic [INSTR_W-1:0] Instruction,
  output logic               IF_Valid
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   buf_pc_q, buf_pc_d;
  logic [INSTR_W-1:0]  buf_instr_q, buf_instr_d;
  logic                buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0]   pc_inc;

  assign pc_inc = pc_q + ADDR_W'(PC_STEP);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_out_d    = pc_out_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    buf_valid_d = buf_valid_q;

    if (Branch_Taken) begin
      pc_d        = Branch_Addr;
      pc_out_d    = '0;
      instr_d     = '0;
      valid_d     = 1'b0;
      buf_valid_d = 1'b0;
      case (state_q)
        FETCH:   state_d = imem_ack ? FETCH : DRAIN;
        DRAIN:   state_d = DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (imem_ack) begin
            pc_d = pc_inc;
            if (!Freeze) begin
              pc_out_d = pc_inc;
              instr_d  = imem_rdata;
              valid_d  = 1'b1;
            end else begin
              buf_pc_d    = pc_inc;
              buf_instr_d = imem_rdata;
              buf_valid_d = 1'b1;
              state_d     = HOLD;
            end
          end else if (!Freeze) begin
            pc_out_d = '0;
            instr_d  = '0;
            valid_d  = 1'b0;
          end
        end
        HOLD: begin
          if (!Freeze) begin
            pc_out_d    = buf_pc_q;
            instr_d     = buf_instr_q;
            valid_d     = buf_valid_q;
            buf_valid_d = 1'b0;
            state_d     = FETCH;
          end
        end
        DRAIN: begin
          // The response to the abandoned address is thrown away.
          pc_out_d = '0;
          instr_d  = '0;
          valid_d  = 1'b0;
          if (imem_ack) state_d = FETCH;
        end
        default: state_d = IDLE;
      endcase
    end

    // A fresh address is only presented when entering/staying in FETCH;
    // DRAIN keeps the old address stable until its ack.
    addr_d = (state_d == FETCH) ? pc_d : addr_q;
    req_d  = (state_d == FETCH) || (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      addr_q      <= '0;
      req_q       <= 1'b0;
      pc_out_q    <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      pc_out_q    <= pc_out_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign PC_out      = pc_out_q;
  assign Instruction = instr_q;
  assign IF_Valid    = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage with a wait-state memory model
// that returns 0xE0000000 + address.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Freeze = 1'b0;
  logic        Branch_Taken = 1'b0;
  logic [31:0] Branch_Addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic [31:0] Instruction;
  logic        IF_Valid;

  int          checks = 0;
  int          errors = 0;
  int          waits = 0;
  logic        stall_mem = 1'b0;
  int          wait_cnt = 0;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .Freeze(Freeze), .Branch_Taken(Branch_Taken),
    .Branch_Addr(Branch_Addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC_out(PC_out),
    .Instruction(Instruction), .IF_Valid(IF_Valid)
  );

  always #5 clk = ~clk;

  assign imem_ack   = imem_req && (wait_cnt >= waits) && !stall_mem;
  assign imem_rdata = 32'hE000_0000 + imem_addr;

  // Counts cycles the current request has been waiting
  always @(posedge clk) begin
    if (!rst || !imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    Freeze = 1'b0;
    Branch_Taken = 1'b0;
    stall_mem = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (imem_req !== 1'b0 || IF_Valid !== 1'b0 || PC_out !== 32'h0 || Instruction !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_state req=%b valid=%b pc_out=%h instr=%h, required 0/0/0/0",
               imem_req, IF_Valid, PC_out, Instruction);
    end
    rst = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || IF_Valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_req req=%b addr=%h valid=%b, required 1/00000000/0",
               imem_req, imem_addr, IF_Valid);
    end
  endtask

  task automatic test_zero_wait();
    waits = 0;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (PC_out !== 32'(4 * i) || Instruction !== 32'hE000_0000 + 32'(4 * (i - 1)) ||
          IF_Valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL zero_wait_%0d pc_out=%h instr=%h valid=%b, required %h/%h/1",
                 i, PC_out, Instruction, IF_Valid, 32'(4 * i), 32'hE000_0000 + 32'(4 * (i - 1)));
      end
    end
  endtask

  task automatic test_wait_states();
    waits = 2;
    do_reset();
    for (int i = 1; i <= 2; i++) begin
      for (int b = 0; b < 2; b++) begin
        step();
        checks++;
        if (IF_Valid !== 1'b0 || Instruction !== 32'h0 || imem_addr !== 32'(4 * (i - 1)) ||
            imem_req !== 1'b1) begin
          errors++;
          $display("[TB] FAIL wait_bubble_%0d_%0d valid=%b instr=%h addr=%h req=%b, required 0/0/%h/1",
                   i, b, IF_Valid, Instruction, imem_addr, imem_req, 32'(4 * (i - 1)));
        end
      end
      step();
      checks++;
      if (IF_Valid !== 1'b1 || PC_out !== 32'(4 * i) ||
          Instruction !== 32'hE000_0000 + 32'(4 * (i - 1))) begin
        errors++;
        $display("[TB] FAIL wait_valid_%0d valid=%b pc_out=%h instr=%h, required 1/%h/%h",
                 i, IF_Valid, PC_out, Instruction, 32'(4 * i), 32'hE000_0000 + 32'(4 * (i - 1)));
      end
    end
    waits = 0;
  endtask

  task automatic test_freeze();
    waits = 0;
    do_reset();
    step();
    step();
    Freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (PC_out !== 32'h8 || Instruction !== 32'hE000_0004 || IF_Valid !== 1'b1 ||
          imem_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL freeze_hold_%0d pc_out=%h instr=%h valid=%b req=%b, required 8/E0000004/1/0",
                 i, PC_out, Instruction, IF_Valid, imem_req);
      end
    end
    Freeze = 1'b0;
    step();
    checks++;
    if (PC_out !== 32'hC || Instruction !== 32'hE000_0008 || IF_Valid !== 1'b1 ||
        imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      errors++;
      $display("[TB] FAIL freeze_release pc_out=%h instr=%h valid=%b req=%b addr=%h, required C/E0000008/1/1/C",
               PC_out, Instruction, IF_Valid, imem_req, imem_addr);
    end
    step();
    checks++;
    if (PC_out !== 32'h10 || Instruction !== 32'hE000_000C) begin
      errors++;
      $display("[TB] FAIL freeze_resume pc_out=%h instr=%h, required 10/E000000C", PC_out, Instruction);
    end
  endtask

  task automatic test_branch_drain();
    int budget;
    waits = 0;
    do_reset();
    budget = 0;
    while (imem_addr !== 32'h20 && budget < 20) begin
      step();
      budget++;
    end
    checks++;
    if (imem_addr !== 32'h20) begin
      errors++;
      $display("[TB] FAIL reach_0x20 addr=%h, required 00000020 within 20 cycles", imem_addr);
    end
    stall_mem = 1'b1;
    step();
    Branch_Taken = 1'b1;
    Branch_Addr = 32'h100;
    step();
    Branch_Taken = 1'b0;
    Branch_Addr = 32'h0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h20 || IF_Valid !== 1'b0 || Instruction !== 32'h0) begin
        errors++;
        $display("[TB] FAIL drain_wait_%0d req=%b addr=%h valid=%b instr=%h, required 1/20/0/0",
                 i, imem_req, imem_addr, IF_Valid, Instruction);
      end
      step();
    end
    stall_mem = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || IF_Valid !== 1'b0 || Instruction !== 32'h0) begin
      errors++;
      $display("[TB] FAIL drain_done req=%b addr=%h valid=%b instr=%h, required 1/100/0/0",
               imem_req, imem_addr, IF_Valid, Instruction);
    end
    step();
    checks++;
    if (PC_out !== 32'h104 || Instruction !== 32'hE000_0100 || IF_Valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL branch_target pc_out=%h instr=%h valid=%b, required 104/E0000100/1",
               PC_out, Instruction, IF_Valid);
    end
  endtask

  task automatic test_branch_in_hold();
    waits = 0;
    do_reset();
    step();
    Freeze = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b0 || PC_out !== 32'h4 || Instruction !== 32'hE000_0000) begin
      errors++;
      $display("[TB] FAIL hold_entry req=%b pc_out=%h instr=%h, required 0/4/E0000000",
               imem_req, PC_out, Instruction);
    end
    Branch_Taken = 1'b1;
    Branch_Addr = 32'h200;
    step();
    Branch_Taken = 1'b0;
    Freeze = 1'b0;
    checks++;
    if (IF_Valid !== 1'b0 || Instruction !== 32'h0 || PC_out !== 32'h0 ||
        imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("[TB] FAIL hold_branch valid=%b instr=%h pc_out=%h req=%b addr=%h, required 0/0/0/1/200",
               IF_Valid, Instruction, PC_out, imem_req, imem_addr);
    end
    step();
    checks++;
    if (PC_out !== 32'h204 || Instruction !== 32'hE000_0200 || IF_Valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_branch_target pc_out=%h instr=%h valid=%b, required 204/E0000200/1",
               PC_out, Instruction, IF_Valid);
    end
  endtask

  task automatic test_wrap();
    waits = 0;
    do_reset();
    Branch_Taken = 1'b1;
    Branch_Addr = 32'hFFFF_FFFC;
    step();
    Branch_Taken = 1'b0;
    checks++;
    if (IF_Valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("[TB] FAIL branch_with_ack valid=%b req=%b addr=%h, required 0/1/FFFFFFFC",
               IF_Valid, imem_req, imem_addr);
    end
    step();
    checks++;
    if (PC_out !== 32'h0 || Instruction !== 32'hDFFF_FFFC || IF_Valid !== 1'b1 ||
        imem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL pc_wrap pc_out=%h instr=%h valid=%b addr=%h, required 0/DFFFFFFC/1/0",
               PC_out, Instruction, IF_Valid, imem_addr);
    end
    step();
    checks++;
    if (PC_out !== 32'h4 || Instruction !== 32'hE000_0000) begin
      errors++;
      $display("[TB] FAIL after_wrap pc_out=%h instr=%h, required 4/E0000000", PC_out, Instruction);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_freeze();
    test_branch_drain();
    test_branch_in_hold();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
